mux_rr_sequencer: RTL
=====================

Name: mux_rr_sequencer

Overview:
- Upstream stage of the 4:1 mux: arbitrates four valid/ready input channels round-robin and registers the winning beat.
- Produces the 2-bit select code and the selected data together with output valid/ready.
- Supports multi-beat packets: once a channel wins, the grant is held until that channel's last beat transfers.
- Output register gives full throughput: one beat per cycle when the downstream stage is always ready.

Parameters:
- DATA_W, 1, width of each channel's data word.
- NUM_CH, 4, number of channels; fixed at 4 to match the 2-bit select. Any other value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel valid.
- in_data  input  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_last  input  4  per-channel end-of-packet flag.
- in_ready  output  4  per-channel ready; one-hot or zero.
- out_valid  output  1  registered beat available.
- out_data  output  DATA_W  registered selected data.
- out_sel  output  2  registered index of the source channel (select code).
- out_last  output  1  registered last flag of the beat.
- out_ready  input  1  downstream accepts the beat.
- locked  output  1  registered; high while in packet state.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, out_last=0, locked=0, state=IDLE, last_grant=3 (so channel 0 has first priority).
- Load enable: load_ok = !out_valid || out_ready.
- in_ready is combinational from in_valid, state, last_grant and out_ready. It is never high when load_ok=0.
- Transfer on channel i = in_valid[i] && in_ready[i].
- IDLE state:
  - Winner is the first channel with in_valid set, searching from (last_grant+1) mod 4 and wrapping upward.
  - in_ready[winner]=load_ok.
  - No valid channel: in_ready=0.
- LOCKED state:
  - Only channel lock_ch may be granted: in_ready[lock_ch] = load_ok.
  - Other channels wait regardless of their valid.
- On a transfer from channel i:
  - out_data <= in_data[i], out_sel <= i, out_last <= in_last[i], out_valid <= 1, last_grant <= i.
  - If in_last[i]=0: state <= LOCKED, lock_ch <= i.
  - If in_last[i]=1: state <= IDLE.
- No transfer and out_ready=1: out_valid <= 0 (register drains).
- out_valid && !out_ready: out_data, out_sel and out_last hold stable. No new transfer occurs.
- Latency is one cycle from input handshake to out_valid.
- Simultaneous drain and load in the same cycle: the new beat replaces the old with no bubble.
- Single-beat packet (in_last=1 on the first beat): no lock, and the next arbitration starts from i+1.
- LOCKED with lock_ch valid low: stall. No other channel is granted and the register drains normally.
- Wrap-around: when last_grant=3, the search order is 0,1,2,3.
- Reset mid-packet: lock is dropped and any in-flight output beat is discarded.
- locked mirrors state==LOCKED.

Decomposition:
- Package mux_seq_pkg:
  - typedef sel_t = logic [1:0].
  - State enum {IDLE, LOCKED}.
  - Constant NUM_CH=4.
- Sub-module rr_pick4 (combinational):
  - Inputs: 4-bit request vector and last_grant.
  - Outputs: found flag and winner index (sel_t).
- The top level holds the FSM, the output register and the ready generation.
- out_sel connects directly to the downstream 4:1 mux select.

Test Plan:
- Reset/priority: rst pulse; in_valid=4'b1111, all in_last=1, out_ready=1.
  - Required: out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid=1 from the first cycle after arbitration onward.
- Packet lock: ch2 sends 3 beats with in_last=0,0,1 while ch0 is valid continuously.
  - Required: out_sel=2,2,2 and locked=1 during the first two beats; then ch0 is granted with out_sel=0 and locked=0.
- Backpressure: out_ready=0 for 4 cycles with a beat held (out_data=1, out_sel=1).
  - Required: out_* stable and in_ready=4'b0000 throughout; on out_ready=1 the next beat loads in the same cycle.
- Wrap: last_grant=3, in_valid=4'b1001.
  - Required: ch0 is granted first, then ch3.
- Lock stall: LOCKED on ch1, in_valid[1] drops for 3 cycles while ch3 is valid.
  - Required: in_ready[3]=0; out_valid falls after the drain; ch1 resumes when its valid returns.
- Reset mid-packet: rst during LOCKED with out_valid=1.
  - Required: out_valid=0 and locked=0 immediately; after release, ch0 has priority.

Source files
------------

// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the round-robin mux sequencer.
// Imported by the arbiter and the sequencer top level.
package mux_seq_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/mux_rr_sequencer_rr_pick4.sv
// Combinational round-robin picker for four requesters.
// The search starts one past last_grant and wraps upward.
module rr_pick4
  import mux_seq_pkg::*;
(
  input  logic [3:0] req,
  input  sel_t       last_grant,
  output logic       found,
  output sel_t       winner
);

  sel_t idx;

  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    idx    = last_grant;
    // Offset 4 wraps back to last_grant itself, so it is searched last.
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + sel_t'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_sequencer.sv
// Round-robin packet sequencer feeding the downstream 4:1 mux.
// Grants are held for a whole packet; the winning beat is registered.
module mux_rr_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int NUM_CH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output sel_t                     out_sel,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     locked
);

  if (NUM_CH != 4) begin : g_bad_num_ch
    $error("mux_rr_sequencer: NUM_CH must be 4 to match the 2-bit select");
  end

  state_t            state;
  state_t            state_next;
  sel_t              lock_ch;
  sel_t              lock_next;
  sel_t              last_grant;
  sel_t              pick_ch;
  logic              pick_found;
  sel_t              grant_ch;
  logic [DATA_W-1:0] grant_data;
  logic              grant_last;
  logic              load_ok;
  logic              xfer;

  assign load_ok = !out_valid || out_ready;

  rr_pick4 u_pick (
    .req        (in_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .winner     (pick_ch)
  );

  // Ready goes to at most one channel: the round-robin winner, or the locked owner.
  always_comb begin
    in_ready = '0;
    grant_ch = pick_ch;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          in_ready[pick_ch] = load_ok;
        end
      end
      LOCKED: begin
        grant_ch          = lock_ch;
        in_ready[lock_ch] = load_ok;
      end
      default: ;
    endcase
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    grant_data = '0;
    grant_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (grant_ch == sel_t'(i)) begin
        grant_data = in_data[i*DATA_W +: DATA_W];
        grant_last = in_last[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    lock_next  = lock_ch;
    if (xfer) begin
      if (grant_last) begin
        state_next = IDLE;
      end else begin
        state_next = LOCKED;
        lock_next  = grant_ch;
      end
    end
  end

  // last_grant resets to 3 so channel 0 gets first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lock_ch    <= '0;
      last_grant <= 2'd3;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      out_last   <= 1'b0;
    end else begin
      state   <= state_next;
      lock_ch <= lock_next;
      if (xfer) begin
        out_valid  <= 1'b1;
        out_data   <= grant_data;
        out_sel    <= grant_ch;
        out_last   <= grant_last;
        last_grant <= grant_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule
